quad_encoder_gen: RTL and testbench
===================================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-002 SHALL have port n_reset, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port i_start, input, 1 bit: begin a move; sampled only in IDLE.
REQ-004 SHALL have port i_stop, input, 1 bit: abort the current move.
REQ-005 SHALL have port i_direction, input, 1 bit: 1 = CW (A leads B), 0 = CCW (B leads A).
REQ-006 SHALL have port i_steps, input, 13 bits: number of quadrature edges (x4 counts) to emit.
REQ-007 SHALL have port i_period, input, 16 bits: clocks between successive edges.
REQ-008 SHALL have port o_A, output, 1 bit: quadrature channel A.
REQ-009 SHALL have port o_B, output, 1 bit: quadrature channel B.
REQ-010 SHALL have port o_position, output, 13 bits: running count of emitted edges, signed by direction.
REQ-011 SHALL have port o_busy, output, 1 bit: high while a move is in progress.
REQ-012 SHALL have port o_done, output, 1 bit: one-cycle pulse at move end (normal or aborted).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 SHALL latch i_direction, i_steps and i_period in IDLE when i_start=1 and i_steps!=0, then enter RUN on the next cycle.
REQ-015 SHALL go IDLE->DONE directly, with no edge emitted, when i_start=1 and i_steps=0.
REQ-016 SHALL treat a latched period below 2 as 2.
REQ-017 SHALL change the quadrature phase exactly P cycles after the start-sampling edge, then every P cycles, where P is the effective period.
REQ-018 SHALL use the phase map 0:(A,B)=(0,0), 1:(1,0), 2:(1,1), 3:(0,1).
REQ-019 SHALL increment the phase mod 4 for each CW edge and decrement it mod 4 for each CCW edge; exactly one of A/B SHALL toggle per edge.
REQ-020 SHALL increment o_position for a CW edge and decrement it for a CCW edge, in the same cycle as the A/B change, wrapping mod 8192.
REQ-021 SHALL enter DONE in the cycle after the Nth edge; DONE SHALL last one cycle with o_done=1 and then return to IDLE.
REQ-022 SHALL take i_stop=1 in RUN to DONE on the next cycle; no further edges SHALL be emitted and the phase and position SHALL be held.
REQ-023 SHALL give i_stop priority over an edge due in the same cycle; that edge SHALL be suppressed.
REQ-024 SHALL ignore i_start in RUN and DONE, and ignore i_stop in IDLE.
REQ-025 SHALL drive o_busy=1 in RUN, 0 otherwise.
REQ-026 SHALL hold phase (and thus A/B) and o_position between moves; a new move SHALL continue from the held phase.
REQ-027 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, on clk rising edge with n_reset=0, set state=IDLE, phase=0, o_A=0, o_B=0, o_position=0, o_busy=0, o_done=0, timer=0 and edge count=0.
REQ-029 SHALL abandon a move when reset is asserted mid-move, without pulsing o_done.

Structure
REQ-030 SHALL place the state encodings (IDLE=0, RUN=1, DONE=2), the phase-to-AB table and the minimum period (2) in a shared constants package, also used by the quad decoder bench.
REQ-031 SHALL use one sub-module, edge_timer: 16-bit down-counter with load and a one-cycle tick output.

Verification
REQ-032 SHALL cover: start, CW, steps=8, period=4 -> edges at cycles 4,8,...,32 after the start; AB sequence 00,10,11,01,00,...; o_position=8; o_done at cycle 33.
REQ-033 SHALL cover: start, CCW, steps=4, period=3, from phase 0 -> AB sequence 01,11,10,00; o_position from 0 to 8188.
REQ-034 SHALL cover: i_stop asserted 1 cycle before the 3rd edge of a 10-step move -> exactly 2 edges, position=2, o_done the next cycle, no further A/B toggles.
REQ-035 SHALL cover: steps=0 -> o_done the cycle after start, o_busy never high; period=0 -> edges every 2 cycles.
REQ-036 SHALL cover: i_start pulsed during RUN -> ignored; n_reset low mid-move -> A=B=0, position=0, busy=0, no o_done.
REQ-037 SHALL cover loopback through the existing quad decoder: 500 CW edges, period=16 -> decoder count=500; then 200 CCW edges -> decoder count=300.

Source files
------------

// File: rtl/quad_encoder_gen_pkg.sv
// Shared constants for the quadrature encoder generator and its decoder bench:
// FSM encodings, phase-to-(A,B) table and the minimum edge period.
package quad_encoder_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] MIN_PERIOD = 16'd2;

  // Index = phase, entry = {A,B}: 0:00, 1:10, 2:11, 3:01
  localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
    return PHASE_AB[phase];
  endfunction

  // Periods below the minimum would make successive edges indistinguishable.
  function automatic logic [15:0] eff_period(input logic [15:0] period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_edge_timer.sv
// edge_timer: 16-bit down-counter with synchronous load; tick_o is high for
// the one cycle in which the count sits at 1 while enabled.
module edge_timer (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  output logic        tick_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Load has priority; otherwise count down while enabled, saturating at 0.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 16'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = en_i && (count_q == 16'd1);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits i_steps A/B edges spaced i_period
// clocks apart in the latched direction, tracking a signed position.
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_direction,
  input  logic [12:0] i_steps,
  input  logic [15:0] i_period,
  output logic        o_A,
  output logic        o_B,
  output logic [12:0] o_position,
  output logic        o_busy,
  output logic        o_done
);

  state_t      state_q,     state_d;
  logic [1:0]  phase_q,     phase_d;
  logic [12:0] pos_q,       pos_d;
  logic [12:0] remaining_q, remaining_d;
  logic        dir_q,       dir_d;
  logic [15:0] period_q,    period_d;
  logic [1:0]  ab_d;
  logic        a_q, b_q, busy_q, done_q;

  logic        tmr_load;
  logic [15:0] tmr_load_val;
  logic        tmr_tick;

  // The timer is loaded with P on the start-sampling edge and reloaded on
  // every emitted edge, so edges land exactly P, 2P, ... cycles after start.
  edge_timer u_edge_timer (
    .clk        (clk),
    .n_reset    (n_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (state_q == ST_RUN),
    .tick_o     (tmr_tick)
  );

  // Next-state logic: move sequencing, edge emission and abort handling.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pos_d        = pos_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    period_d     = period_q;
    tmr_load     = 1'b0;
    tmr_load_val = period_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_steps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_RUN;
            dir_d        = i_direction;
            remaining_d  = i_steps;
            period_d     = eff_period(i_period);
            tmr_load     = 1'b1;
            tmr_load_val = eff_period(i_period);
          end
        end
      end
      ST_RUN: begin
        // Stop wins over an edge due in the same cycle; after the last edge
        // one further RUN cycle elapses before DONE.
        if (i_stop || (remaining_q == '0)) begin
          state_d = ST_DONE;
        end else if (tmr_tick) begin
          phase_d     = dir_q ? (phase_q + 2'd1) : (phase_q - 2'd1);
          pos_d       = dir_q ? (pos_q + 13'd1) : (pos_q - 13'd1);
          remaining_d = remaining_q - 13'd1;
          tmr_load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ab_d = phase_to_ab(phase_d);

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      pos_q       <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      period_q    <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      a_q         <= ab_d[1];
      b_q         <= ab_d[0];
      busy_q      <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_position = pos_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: directed table, random moves
// against an arithmetic move model, reset/abort sequences, decoder loopback.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_direction = 1'b0;
  logic [12:0] i_steps = '0;
  logic [15:0] i_period = '0;
  logic        o_A, o_B, o_busy, o_done;
  logic [12:0] o_position;

  int checks = 0;
  int errors = 0;
  int ph_m = 0;
  int pos_m = 0;
  int done_seen_at = -1;
  int dec_count = 0;
  int dec_prev = 0;

  quad_encoder_gen dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_direction (i_direction),
    .i_steps     (i_steps),
    .i_period    (i_period),
    .o_A         (o_A),
    .o_B         (o_B),
    .o_position  (o_position),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  function automatic int ab_to_phase(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference quadrature decoder: counts +1/-1 per legal phase step.
  always @(posedge clk) begin
    int ph_now, diff;
    if (!n_reset) begin
      dec_count <= 0;
      dec_prev  <= 0;
    end else begin
      ph_now = ab_to_phase(o_A, o_B);
      diff = (ph_now - dec_prev + 4) % 4;
      if (diff == 1) dec_count <= dec_count + 1;
      else if (diff == 3) dec_count <= dec_count - 1;
      dec_prev <= ph_now;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    ph_m  = 0;
    pos_m = 0;
  endtask

  // Runs one move from a negedge and checks every cycle against a model
  // derived from the move parameters alone: edges at t0+k*P, done at td.
  task automatic run_move(input string tag, input bit dir, input int steps,
                          input int period, input int stop_rel, input int pulse_rel);
    int p, td, e, lim, sgn, ph, pos;
    int a_tab[4];
    int b_tab[4];
    a_tab = '{0, 1, 1, 0};
    b_tab = '{0, 0, 1, 1};
    p   = (period < 2) ? 2 : period;
    sgn = dir ? 1 : -1;
    if (steps == 0) begin
      td = 0;
    end else begin
      td = steps * p + 1;
      if (stop_rel > 0 && stop_rel < td) td = stop_rel;
    end
    done_seen_at = -1;
    ph  = ph_m;
    pos = pos_m;
    for (int c = 0; c <= td + 1; c++) begin
      if (c == 0) begin
        i_start     = 1'b1;
        i_direction = dir;
        i_steps     = 13'(steps);
        i_period    = 16'(period);
        i_stop      = (stop_rel == 0);
      end else begin
        i_stop  = (c == stop_rel);
        i_start = (c == pulse_rel);
      end
      @(negedge clk);
      if (steps == 0) begin
        e = 0;
      end else begin
        lim = (c < td) ? c : td - 1;
        e = lim / p;
        if (e > steps) e = steps;
      end
      ph  = (((ph_m + sgn * e) % 4) + 4) % 4;
      pos = (((pos_m + sgn * e) % 8192) + 8192) % 8192;
      chk($sformatf("%s.A@%0d", tag, c), int'(o_A), a_tab[ph]);
      chk($sformatf("%s.B@%0d", tag, c), int'(o_B), b_tab[ph]);
      chk($sformatf("%s.pos@%0d", tag, c), int'(o_position), pos);
      chk($sformatf("%s.busy@%0d", tag, c), int'(o_busy), int'(steps != 0 && c < td));
      chk($sformatf("%s.done@%0d", tag, c), int'(o_done), int'(c == td));
      if (o_done && done_seen_at < 0) done_seen_at = c;
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    ph_m  = ph;
    pos_m = pos;
  endtask

  typedef struct {
    bit rst;
    bit dir;
    int steps;
    int period;
    int stop_rel;
    int pulse_rel;
    int exp_pos;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // rst dir steps period stop pulse | exp_pos exp_done
    vecs[0] = '{1'b1, 1'b1,  8, 4, -1, -1,    8, 33};
    vecs[1] = '{1'b1, 1'b0,  4, 3, -1, -1, 8188, 13};
    vecs[2] = '{1'b1, 1'b1, 10, 5, 14, -1,    2, 14};
    vecs[3] = '{1'b0, 1'b1,  0, 7, -1, -1,    2,  0};
    vecs[4] = '{1'b0, 1'b1,  6, 0, -1, -1,    8, 13};
    vecs[5] = '{1'b0, 1'b0,  5, 3, -1,  4,    3, 16};
    vecs[6] = '{1'b0, 1'b1,  6, 3,  6, -1,    4,  6};
    vecs[7] = '{1'b0, 1'b1,  3, 2,  0, -1,    7,  7};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.A", int'(o_A), 0);
    chk("rst.B", int'(o_B), 0);
    chk("rst.pos", int'(o_position), 0);
    chk("rst.busy", int'(o_busy), 0);
    chk("rst.done", int'(o_done), 0);
    n_reset = 1'b1;
    @(negedge clk);

    // i_stop in IDLE is ignored
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    chk("idle_stop.busy", int'(o_busy), 0);
    chk("idle_stop.done", int'(o_done), 0);
    @(negedge clk);
    chk("idle_stop.done2", int'(o_done), 0);

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_move($sformatf("vec%0d", i), vecs[i].dir, vecs[i].steps, vecs[i].period,
               vecs[i].stop_rel, vecs[i].pulse_rel);
      chk($sformatf("vec%0d.final_pos", i), int'(o_position), vecs[i].exp_pos);
      chk($sformatf("vec%0d.done_cycle", i), done_seen_at, vecs[i].exp_done);
    end

    // Reset asserted mid-move: outputs cleared, no done pulse afterwards
    do_reset();
    i_start = 1'b1; i_direction = 1'b1; i_steps = 13'd10; i_period = 16'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst.pos_before", int'(o_position), 2);
    n_reset = 1'b0;
    @(negedge clk);
    chk("midrst.A", int'(o_A), 0);
    chk("midrst.B", int'(o_B), 0);
    chk("midrst.pos", int'(o_position), 0);
    chk("midrst.busy", int'(o_busy), 0);
    chk("midrst.done", int'(o_done), 0);
    n_reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("midrst.after_done@%0d", c), int'(o_done), 0);
      chk($sformatf("midrst.after_pos@%0d", c), int'(o_position), 0);
    end
    ph_m = 0;
    pos_m = 0;

    // Randomised moves against the model
    for (int r = 0; r < 30; r++) begin
      int st, pe, sr, pr, pe_eff;
      st = int'($urandom_range(0, 12));
      pe = int'($urandom_range(0, 5));
      pe_eff = (pe < 2) ? 2 : pe;
      sr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, st * pe_eff + 2)) : -1;
      pr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_move($sformatf("rnd%0d", r), bit'($urandom_range(0, 1)), st, pe, sr, pr);
    end

    // Loopback through the reference decoder
    do_reset();
    run_move("loop_cw", 1'b1, 500, 16, -1, -1);
    @(negedge clk);
    chk("loop.dec_cw", dec_count, 500);
    run_move("loop_ccw", 1'b0, 200, 16, -1, -1);
    @(negedge clk);
    chk("loop.dec_ccw", dec_count, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
